packer_nto64: RTL and testbench

Parametrised single-clock packer that concatenates a stream of SAMPLE_W-bit samples (or NARROW_W-bit samples in narrow mode) into a gap-free MSB-first bitstream. It cuts that bitstream into 64-bit words and buffers them in a small first-word-fall-through (FWFT) output queue with a valid/ready handshake. It sits between the ADC/sample capture logic and the DDR write path. It generalises the fixed 18/8-bit packer with:

- arbitrary sample width;
- flush of a final partial word with a bit count;
- backpressure with overflow detection;
- a done handshake.

---
 rtl/packer_nto64.sv | 237 +++++++++++++++++++++++
 tb/tb_packer_nto64.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_nto64.sv
// packer_nto64
// Concatenates SAMPLE_W-bit samples (or NARROW_W-bit samples in narrow mode)
// into a gap-free MSB-first bitstream and cuts it into 64-bit words. Words are
// buffered in a first-word-fall-through queue of OUT_DEPTH entries.
//
// Ports
//   clk, reset_n     : sole clock, asynchronous active-low reset
//   enable           : low = idle, accumulator and queue cleared
//   capture_start    : pulse, clears capture state and latches I_narrow_mode
//   capture_done     : pulse, ends the capture and flushes the partial word
//   I_narrow_mode    : 1 = samples are I_data[NARROW_W-1:0]
//   I_data, I_wr     : sample and its strobe
//   O_data/O_last/O_bits : head word, final-partial flag, valid MSB bit count
//   O_valid, O_ready : output handshake
//   O_overflow       : sticky, a word was dropped on a full queue
//   O_words          : words pushed since capture_start (wrapping)
//   flush_done       : one-cycle pulse once the flush is done and queue empty
//   o_dbg_state      : current FSM state (IDLE=0, RUN=1, FLUSH=2, DRAIN=3)
//
// Handshake: the head word is transferred on every rising edge where
// O_valid && O_ready; O_data/O_last/O_bits are stable while O_valid is high
// and not accepted, and O_valid does not depend on O_ready.
module packer_nto64 #(
   parameter int SAMPLE_W  = 18,
   parameter int NARROW_W  = 8,
   parameter int OUT_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                capture_start,
   input  logic                capture_done,
   input  logic                I_narrow_mode,
   input  logic [SAMPLE_W-1:0] I_data,
   input  logic                I_wr,
   output logic [63:0]         O_data,
   output logic                O_valid,
   input  logic                O_ready,
   output logic                O_last,
   output logic [6:0]          O_bits,
   output logic                O_overflow,
   output logic [15:0]         O_words,
   output logic                flush_done,
   output logic [1:0]          o_dbg_state
);

   // One bit short of 64+SAMPLE_W: the fill is at most 63 before an append.
   localparam int ACC_W = 64 + SAMPLE_W - 1;
   localparam int AW    = $clog2(OUT_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ACC_W-1:0]    r_acc;
   logic [6:0]          r_fill;
   logic                r_narrow;

   // Word staged for the queue; written one edge after it is formed.
   logic                r_push_vld;
   logic [63:0]         r_push_data;
   logic                r_push_last;
   logic [6:0]          r_push_bits;

   logic [71:0]         r_mem [OUT_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;

   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_clear;
   logic                w_push_ok;
   logic                w_drop;
   logic                w_drained;
   logic [71:0]         w_head;

   logic [7:0]          w_width;
   logic [SAMPLE_W-1:0] w_narrow_ext;
   logic [SAMPLE_W-1:0] w_sample_left;
   logic [ACC_W-1:0]    w_ins;
   logic [ACC_W-1:0]    w_acc_sum;
   logic [ACC_W-1:0]    w_acc_rem;
   logic [7:0]          w_fill_sum;

   // ---------------------------------------------------------------- queue
   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop     = !w_empty && O_ready;
      w_clear   = !enable || capture_start;
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      w_push_ok = r_push_vld && (!w_full || w_pop);
      w_drop    = r_push_vld && w_full && !w_pop;
      w_drained = w_empty && !r_push_vld;
      w_head    = r_mem[r_rd_ptr[AW-1:0]];
   end

   always_comb begin
      O_valid = !w_empty;
      O_data  = '0;
      O_last  = 1'b0;
      O_bits  = '0;
      if (!w_empty) begin
         O_data = w_head[71:8];
         O_last = w_head[7];
         O_bits = w_head[6:0];
      end
   end

   // ------------------------------------------------------------ packing
   always_comb begin
      w_width       = r_narrow ? 8'(NARROW_W) : 8'(SAMPLE_W);
      w_narrow_ext  = '0;
      w_narrow_ext[NARROW_W-1:0] = I_data[NARROW_W-1:0];
      // Left-align the sample so both modes append from the same MSB position.
      w_sample_left = r_narrow ? (w_narrow_ext << (SAMPLE_W - NARROW_W)) : I_data;
      w_ins         = {w_sample_left, {(ACC_W-SAMPLE_W){1'b0}}} >> r_fill;
      w_acc_sum     = r_acc | w_ins;
      w_acc_rem     = w_acc_sum << 64;
      w_fill_sum    = {1'b0, r_fill} + w_width;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      flush_done  = 1'b0;
      if (!enable) begin
         w_state_nxt = S_IDLE;
      end else if (capture_start) begin
         w_state_nxt = S_RUN;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_RUN:   if (capture_done) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DRAIN;
            S_DRAIN: begin
               if (w_drained) begin
                  flush_done  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign o_dbg_state = r_state;

   // -------------------------------------------------- accumulator / staging
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_narrow    <= 1'b0;
         r_push_vld  <= 1'b0;
         r_push_data <= '0;
         r_push_last <= 1'b0;
         r_push_bits <= '0;
      end else if (w_clear) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_push_vld  <= 1'b0;
         r_push_data <= '0;
         r_push_last <= 1'b0;
         r_push_bits <= '0;
         if (enable) r_narrow <= I_narrow_mode;
      end else begin
         r_push_vld <= 1'b0;
         if (r_state == S_RUN && I_wr) begin
            if (w_fill_sum >= 8'd64) begin
               r_push_vld  <= 1'b1;
               r_push_data <= w_acc_sum[ACC_W-1 -: 64];
               r_push_last <= 1'b0;
               r_push_bits <= 7'd64;
               r_acc       <= w_acc_rem;
               r_fill      <= 7'(w_fill_sum - 8'd64);
            end else begin
               r_acc  <= w_acc_sum;
               r_fill <= w_fill_sum[6:0];
            end
         end else if (r_state == S_FLUSH && r_fill != 7'd0) begin
            // Bits below the fill are already zero, so this is zero-padded.
            r_push_vld  <= 1'b1;
            r_push_data <= r_acc[ACC_W-1 -: 64];
            r_push_last <= 1'b1;
            r_push_bits <= r_fill;
            r_acc       <= '0;
            r_fill      <= '0;
         end
      end
   end

   // ------------------------------------------------ queue pointers / stats
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         O_overflow <= 1'b0;
         O_words    <= '0;
      end else if (!enable) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (capture_start) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         O_overflow <= 1'b0;
         O_words    <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            O_words  <= O_words + 16'd1;
         end
         if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
         if (w_drop) O_overflow <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible through O_valid.
   always_ff @(posedge clk) begin
      if (!w_clear && w_push_ok)
         r_mem[r_wr_ptr[AW-1:0]] <= {r_push_data, r_push_last, r_push_bits};
   end

endmodule

// File: tb/tb_packer_nto64.sv
module tb_packer_nto64;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        capture_start;
   logic        capture_done;
   logic        I_narrow_mode;
   logic [17:0] I_data;
   logic        I_wr;
   logic [63:0] O_data;
   logic        O_valid;
   logic        O_ready;
   logic        O_last;
   logic [6:0]  O_bits;
   logic        O_overflow;
   logic [15:0] O_words;
   logic        flush_done;
   logic [1:0]  dbg_state;

   packer_nto64 #(.SAMPLE_W(18), .NARROW_W(8), .OUT_DEPTH(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .capture_start (capture_start),
      .capture_done  (capture_done),
      .I_narrow_mode (I_narrow_mode),
      .I_data        (I_data),
      .I_wr          (I_wr),
      .O_data        (O_data),
      .O_valid       (O_valid),
      .O_ready       (O_ready),
      .O_last        (O_last),
      .O_bits        (O_bits),
      .O_overflow    (O_overflow),
      .O_words       (O_words),
      .flush_done    (flush_done),
      .o_dbg_state   (dbg_state)
   );

   // ------------------------------------------------------ clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------------------------------------------------- scoreboard
   // Entry = {data[63:0], last, bits[6:0]}
   logic [71:0] exp_q[$];
   bit          mdl_bits[$];
   bit          mdl_narrow;
   logic [6:0]  last_bits_seen;
   logic [63:0] first_word;
   bit          have_first;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Reference bitstream: every sample bit goes into a bit queue, words are
   // cut from its front.
   task automatic model_push(input logic [17:0] s);
      int w;
      logic [63:0] wd;
      w = mdl_narrow ? 8 : 18;
      for (int i = w - 1; i >= 0; i--) mdl_bits.push_back(s[i]);
      if (mdl_bits.size() >= 64) begin
         for (int i = 63; i >= 0; i--) wd[i] = mdl_bits.pop_front();
         exp_q.push_back({wd, 1'b0, 7'd64});
      end
   endtask

   task automatic model_flush();
      int n;
      logic [63:0] wd;
      n = mdl_bits.size();
      wd = '0;
      if (n > 0) begin
         for (int i = 63; i >= 64 - n; i--) wd[i] = mdl_bits.pop_front();
         exp_q.push_back({wd, 1'b1, 7'(n)});
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && O_valid && O_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got %h bits %0d", O_data, O_bits);
         end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            if ({O_data, O_last, O_bits} !== e) begin
               errors++;
               $display("FAIL word got %h last %0b bits %0d want %h last %0b bits %0d",
                        O_data, O_last, O_bits, e[71:8], e[7], e[6:0]);
            end
         end
         if (O_last) last_bits_seen = O_bits;
         if (!have_first) begin
            first_word = O_data;
            have_first = 1'b1;
         end
      end
   end

   // -------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_capture(input bit narrow);
      capture_start = 1'b1;
      I_narrow_mode = narrow;
      tick();
      capture_start = 1'b0;
      // Mode must stay latched from capture_start.
      I_narrow_mode = ~narrow;
      mdl_narrow = narrow;
      mdl_bits.delete();
      last_bits_seen = '0;
      have_first = 1'b0;
   endtask

   task automatic send(input logic [17:0] s, input bit use_model);
      I_wr = 1'b1;
      I_data = s;
      if (use_model) model_push(s);
      tick();
      I_wr = 1'b0;
   endtask

   task automatic finish_capture(input bit chk_lat);
      int k;
      capture_done = 1'b1;
      model_flush();
      @(posedge clk);
      #1;
      capture_done = 1'b0;
      I_wr = 1'b0;
      k = 0;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (flush_done) begin
            k = j;
            break;
         end
      end
      check("flush_done_seen", 64'(k != 0), 64'd1);
      if (chk_lat) check("flush_latency", 64'(k), 64'd2);
      @(negedge clk);
      check("flush_done_pulse", 64'(flush_done), 64'd0);
      check("state_idle", 64'(dbg_state), 64'd0);
      tick();
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      bit          narrow;
      int          n;
      logic [17:0] base;
      logic [17:0] step;
      bit          rnd;
      int          exp_words;
      int          exp_last_bits;
      bit          chk_first;
      logic [63:0] exp_first;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [17:0] s;

      tbl[0] = '{0, 32, 18'd1,    18'd1,    0, 9, 0,  1, {18'd1, 18'd2, 18'd3, 10'd0}};
      tbl[1] = '{1, 8,  18'h11,   18'h11,   0, 1, 0,  1, 64'h1122334455667788};
      tbl[2] = '{0, 5,  18'd1,    18'd1,    0, 2, 26, 0, 64'd0};
      tbl[3] = '{0, 20, 18'd0,    18'd0,    1, 6, 40, 0, 64'd0};
      tbl[4] = '{1, 13, 18'd0,    18'd0,    1, 2, 40, 0, 64'd0};

      reset_n = 1'b0;
      enable = 1'b1;
      capture_start = 1'b0;
      capture_done = 1'b0;
      I_narrow_mode = 1'b0;
      I_data = '0;
      I_wr = 1'b0;
      O_ready = 1'b1;
      mdl_narrow = 1'b0;
      last_bits_seen = '0;
      first_word = '0;
      have_first = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(O_valid), 64'd0);
      check("rst_data", O_data, 64'd0);
      check("rst_bits", 64'(O_bits), 64'd0);
      check("rst_last", 64'(O_last), 64'd0);
      check("rst_overflow", 64'(O_overflow), 64'd0);
      check("rst_words", 64'(O_words), 64'd0);
      check("rst_flush_done", 64'(flush_done), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      reset_n = 1'b1;
      tick();

      // Table-driven captures with O_ready held high.
      for (int i = 0; i < 5; i++) begin
         O_ready = 1'b1;
         start_capture(tbl[i].narrow);
         for (int k = 0; k < tbl[i].n; k++) begin
            s = tbl[i].rnd ? 18'($urandom_range(0, 262143))
                           : 18'(tbl[i].base + 18'(k) * tbl[i].step);
            send(s, 1'b1);
         end
         finish_capture(tbl[i].exp_last_bits == 0);
         check($sformatf("v%0d_words", i), 64'(O_words), 64'(tbl[i].exp_words));
         check($sformatf("v%0d_last_bits", i), 64'(last_bits_seen), 64'(tbl[i].exp_last_bits));
         check($sformatf("v%0d_queue_left", i), 64'(exp_q.size()), 64'd0);
         if (tbl[i].chk_first) check($sformatf("v%0d_first", i), first_word, tbl[i].exp_first);
      end

      // Word-completing I_wr in the same cycle as capture_done.
      O_ready = 1'b1;
      start_capture(1'b0);
      send(18'd1, 1'b1);
      send(18'd2, 1'b1);
      send(18'd3, 1'b1);
      I_wr = 1'b1;
      I_data = 18'd4;
      model_push(18'd4);
      finish_capture(1'b0);
      check("same_cycle_words", 64'(O_words), 64'd2);
      check("same_cycle_last_bits", 64'(last_bits_seen), 64'd8);
      check("same_cycle_queue_left", 64'(exp_q.size()), 64'd0);

      // Backpressure: 5 words into a 4-deep queue.
      O_ready = 1'b0;
      start_capture(1'b0);
      for (int k = 0; k < 18; k++) send(18'($urandom_range(0, 262143)), 1'b1);
      repeat (3) tick();
      void'(exp_q.pop_back());  // the fifth word is dropped
      check("ovf_valid", 64'(O_valid), 64'd1);
      check("ovf_flag", 64'(O_overflow), 64'd1);
      check("ovf_words", 64'(O_words), 64'd4);
      check("ovf_head_bits", 64'(O_bits), 64'd64);
      O_ready = 1'b1;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (!O_valid) break;
      end
      check("ovf_drained", 64'(O_valid), 64'd0);
      check("ovf_queue_left", 64'(exp_q.size()), 64'd0);
      check("ovf_sticky", 64'(O_overflow), 64'd1);
      start_capture(1'b0);
      check("ovf_cleared", 64'(O_overflow), 64'd0);
      check("ovf_words_cleared", 64'(O_words), 64'd0);
      finish_capture(1'b1);

      // enable low clears the queue but holds O_words.
      O_ready = 1'b0;
      start_capture(1'b0);
      for (int k = 0; k < 4; k++) send(18'($urandom_range(0, 262143)), 1'b1);
      repeat (2) tick();
      check("en_valid_before", 64'(O_valid), 64'd1);
      enable = 1'b0;
      tick();
      exp_q.delete();
      check("en_valid_after", 64'(O_valid), 64'd0);
      check("en_words_held", 64'(O_words), 64'd1);
      check("en_state", 64'(dbg_state), 64'd0);
      enable = 1'b1;
      tick();

      // Asynchronous reset mid-capture.
      O_ready = 1'b0;
      start_capture(1'b0);
      for (int k = 0; k < 8; k++) send(18'($urandom_range(0, 262143)), 1'b1);
      repeat (2) tick();
      check("arst_valid_before", 64'(O_valid), 64'd2 - 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(O_valid), 64'd0);
      check("arst_data", O_data, 64'd0);
      check("arst_words", 64'(O_words), 64'd0);
      check("arst_state", 64'(dbg_state), 64'd0);
      exp_q.delete();
      mdl_bits.delete();
      tick();
      reset_n = 1'b1;
      O_ready = 1'b1;
      for (int k = 0; k < 10; k++) send(18'($urandom_range(0, 262143)), 1'b0);
      repeat (4) tick();
      check("arst_no_words_valid", 64'(O_valid), 64'd0);
      check("arst_no_words_count", 64'(O_words), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
